quad_emulator: RTL and testbench
================================

# quad_emulator

Quadrature encoder signal generator: turns a signed step command into an A/B quadrature waveform at a programmable edge rate. It is the transmit counterpart of the motor board's quadrature counter. It drives encoder-input pins in hardware-in-the-loop tests, and it can be looped back into a `quad` counter on the same `CLK` (32 MHz PLL domain) for self-test of the position/velocity path.

## Interface
- `CNT_W`, default 32: width of `cmd_steps` and `position`.
- `DIV_W`, default 16: width of `cmd_period`.

Ports:
- `CLK` in 1: system clock (32 MHz PLL output).
- `reset` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_steps` in CNT_W: signed edge count. Positive means A leads B.
- `cmd_period` in DIV_W: unsigned clocks per quadrature edge. 0 is treated as 1.
- `abort` in 1: terminate the current run.
- `pos_clear` in 1: zero `position`.
- `quadA` out 1: encoder channel A, registered.
- `quadB` out 1: encoder channel B, registered.
- `position` out CNT_W: signed running count of emitted edges.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run completes normally.

## Operation
- **States:** IDLE, RUN.
- **Reset** (`reset`=0 at a clock edge), same edge, overriding everything:
  - state=IDLE
  - quadA=0, quadB=0, position=0
  - busy=0, done=0, cmd_ready=1
  - internal timer=0, remaining=0, phase=0
- **IDLE:** `cmd_ready`=1. On `cmd_valid & cmd_ready` at a clock edge:
  - latch direction = sign(`cmd_steps`)
  - latch remaining = |`cmd_steps`| as unsigned CNT_W. -2^(CNT_W-1) gives 2^(CNT_W-1), with no overflow.
  - latch timer = max(`cmd_period`, 1)
  - if remaining≠0: go to RUN, busy=1
  - if remaining=0: stay in IDLE and pulse `done` on the next edge, with no A/B change.
- **RUN:** `cmd_ready`=0, and `cmd_valid` is ignored. Each clock, timer decrements. On the edge where timer==1:
  - phase advances one step: +1 for positive direction, -1 for negative.
  - position += +1 or -1.
  - remaining -= 1.
  - timer reloads with the latched period.
- **End of run:** when remaining reaches 0 on an edge, go to IDLE on that same edge, with busy=0, done=1 for one cycle, and cmd_ready=1.
- **Phase encoding** (A,B) = phase 0:00, 1:10, 2:11, 3:01. Phase is 2 bits and wraps 3→0 and 0→3. Exactly one of A/B toggles per edge; there are never simultaneous toggles.
- **A/B state is persistent:** it is not reset between commands, so consecutive runs are glitch-free and continuous.
- **abort=1 in RUN:** go to IDLE on the next edge. A/B hold their current level. No edge is emitted on that cycle, even if timer==1. `done` is not pulsed. In IDLE, abort has no effect.
- **pos_clear=1:** position=0 on that edge. This takes priority over a simultaneous edge increment, but the A/B edge is still emitted.
- **position wrap:** two's-complement wrap-around at ±2^(CNT_W-1).
- **Mid-command period changes:** changes to `cmd_period` or `cmd_steps` during RUN are ignored; the values are latched at acceptance.

## Timing
- **First edge:** command accepted at edge T gives the first A/B edge at edge T+P, where P = max(period,1).
- **Later edges:** the k-th edge occurs at T+k·P.
- **Completion:** the last edge, busy falling, and `done` all occur on edge T+N·P, with N=|steps|.
- **Back-to-back commands:** the earliest acceptance of the next command is edge T+N·P+1. With P=1, the gap between the last edge of one run and the first edge of the next is therefore 2 cycles.
- **Zero-step command:** accepted at T, `done` is high during the cycle after edge T+1. Note: done is registered the edge after acceptance.
- **Output glitches:** all outputs are registered, so quadA/quadB are glitch-free and directly usable as pin drivers.
- **Maximum edge rate:** CLK/1, i.e. P=1. The receiving counter's filter depth bounds the usable rate. For loopback with `quad #(5)`, use P≥8.

## Test plan
- **Forward run:** reset, then steps=+4, period=3. Required: A/B sequence 00→10→11→01→00, edges at T+3, 6, 9, 12; position=4; done a single pulse at T+12; busy high T+1..T+12.
- **Reverse run:** steps=-2, period=0 (treated as 1). Required: A/B 00→01→11, edges at T+1 and T+2, position=-2, done at T+2.
- **Zero steps:** steps=0. Required: no A/B change, `done` one-cycle pulse, cmd_ready stays 1, position unchanged.
- **Abort mid-run:** steps=+10, period=2, abort asserted at T+5. Required: exactly 2 edges emitted, A/B frozen at 11, position=2, no done pulse, cmd_ready=1 at T+6. A new steps=+1 command then yields A/B=01.
- **Wrap and clear:** preload position to 2^31-1 via +2^31-1 steps with P=1, then +1 step. Required: position=-2^31. A pos_clear asserted coinciding with an edge gives position=0 and the A/B edge still occurs.
- **Reset mid-run and loopback:** reset mid-run gives all outputs at reset values on the next edge. Loopback into `quad #(5)` with steps=+1000, P=8: counter reads +1000.

Source files
------------

// File: rtl/quad_emulator.sv
// quad_emulator: quadrature encoder signal generator.
// Accepts a signed step command and emits that many A/B quadrature edges,
// one every max(cmd_period,1) clocks. A leads B for positive steps.
// Ports:
//   CLK, reset        - clock and synchronous active-low reset
//   cmd_valid/ready   - command handshake (ready only in IDLE)
//   cmd_steps         - signed edge count, cmd_period - clocks per edge
//   abort             - stop the current run without a done pulse
//   pos_clear         - zero the running position
//   quadA, quadB      - registered encoder outputs
//   position          - signed running count of emitted edges
//   busy, done        - run in progress / one-cycle completion pulse
module quad_emulator #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             pos_clear,
    output logic             quadA,
    output logic             quadB,
    output logic [CNT_W-1:0] position,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [1:0]       phase_q, phase_d;
    logic             dir_q, dir_d;       // 1 = negative direction
    logic             zdone_q, zdone_d;   // zero-step command pending done
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             qa_q, qa_d;
    logic             qb_q, qb_d;

    logic             step_c;
    logic [CNT_W-1:0] steps_abs_c;
    logic [DIV_W-1:0] period_eff_c;

    // Magnitude of the command; the most negative value maps to 2^(CNT_W-1).
    assign steps_abs_c  = cmd_steps[CNT_W-1] ? (~cmd_steps + CNT_W'(1)) : cmd_steps;
    assign period_eff_c = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        period_d = period_q;
        rem_d    = rem_q;
        pos_d    = pos_q;
        phase_d  = phase_q;
        dir_d    = dir_q;
        zdone_d  = 1'b0;
        done_d   = zdone_q;
        busy_d   = busy_q;
        step_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d    = cmd_steps[CNT_W-1];
                    rem_d    = steps_abs_c;
                    timer_d  = period_eff_c;
                    period_d = period_eff_c;
                    if (steps_abs_c != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (timer_q == DIV_W'(1)) begin
                    step_c  = 1'b1;
                    timer_d = period_q;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (step_c) begin
            phase_d = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
            pos_d   = dir_q ? (pos_q - CNT_W'(1)) : (pos_q + CNT_W'(1));
        end

        // Clear wins over a coincident increment; the A/B edge still happens.
        if (pos_clear) begin
            pos_d = '0;
        end

        ready_d = (state_d == IDLE);
        // Gray decode: 0->00, 1->10, 2->11, 3->01 as (A,B)
        qa_d    = phase_d[1] ^ phase_d[0];
        qb_d    = phase_d[1];
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            period_q <= '0;
            rem_q    <= '0;
            pos_q    <= '0;
            phase_q  <= 2'd0;
            dir_q    <= 1'b0;
            zdone_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            qa_q     <= 1'b0;
            qb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            rem_q    <= rem_d;
            pos_q    <= pos_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            zdone_q  <= zdone_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            qa_q     <= qa_d;
            qb_q     <= qb_d;
        end
    end

    assign cmd_ready = ready_q;
    assign quadA     = qa_q;
    assign quadB     = qb_q;
    assign position  = pos_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_quad_emulator.sv
// Directed testbench for quad_emulator (CNT_W=12 so wrap cases stay short).
module tb_quad_emulator;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned DIV_W = 16;

    logic             CLK = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;
    logic             abort;
    logic             pos_clear;
    logic             quadA;
    logic             quadB;
    logic [CNT_W-1:0] position;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    quad_emulator #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_dut (
        .CLK        (CLK),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .pos_clear  (pos_clear),
        .quadA      (quadA),
        .quadB      (quadB),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    // Independent quadrature decoder used as a loopback receiver
    int   dec_cnt;
    logic dec_clr;
    logic [1:0] dec_prev;

    function automatic logic [1:0] ab_phase(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    always @(posedge CLK) begin
        logic [1:0] cur;
        cur = ab_phase(quadA, quadB);
        if (dec_clr) begin
            dec_cnt  <= 0;
        end else if (cur - dec_prev == 2'd1) begin
            dec_cnt  <= dec_cnt + 1;
        end else if (cur - dec_prev == 2'd3) begin
            dec_cnt  <= dec_cnt - 1;
        end
        dec_prev <= cur;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pos_s();
        int p;
        p = $signed(position);
        return p;
    endfunction

    function automatic int ab();
        return int'({quadA, quadB});
    endfunction

    // Advance n clock edges, then settle 1ns past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Present a command so it is accepted on the next edge (edge T).
    task automatic send(input int steps, input int period);
        cmd_steps  = CNT_W'(steps);
        cmd_period = DIV_W'(period);
        cmd_valid  = 1'b1;
        tick(1);
        cmd_valid  = 1'b0;
    endtask

    task automatic clear_pos();
        pos_clear = 1'b1;
        tick(1);
        pos_clear = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        pos_clear  = 1'b0;
        dec_clr    = 1'b1;
        tick(2);
        check("rst_ab", ab(), 0);
        check("rst_pos", pos_s(), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        reset = 1'b1;
        tick(1);

        // Forward run: +4 steps, period 3; mid-run command changes are ignored
        send(4, 3);
        check("fwd_busy_T", int'(busy), 1);
        check("fwd_ready_T", int'(cmd_ready), 0);
        cmd_steps  = CNT_W'(99);
        cmd_period = DIV_W'(1);
        cmd_valid  = 1'b1;
        tick(2);
        check("fwd_ab_T2", ab(), 0);
        tick(1);
        check("fwd_ab_T3", ab(), 2);
        check("fwd_pos_T3", pos_s(), 1);
        tick(3);
        check("fwd_ab_T6", ab(), 3);
        tick(3);
        check("fwd_ab_T9", ab(), 1);
        tick(2);
        check("fwd_done_T11", int'(done), 0);
        check("fwd_busy_T11", int'(busy), 1);
        cmd_valid = 1'b0;
        tick(1);
        check("fwd_ab_T12", ab(), 0);
        check("fwd_pos_T12", pos_s(), 4);
        check("fwd_done_T12", int'(done), 1);
        check("fwd_busy_T12", int'(busy), 0);
        check("fwd_ready_T12", int'(cmd_ready), 1);
        tick(1);
        check("fwd_done_T13", int'(done), 0);

        // Reverse run: -2 steps, period 0 behaves as 1
        clear_pos();
        check("clr_pos", pos_s(), 0);
        send(-2, 0);
        tick(1);
        check("rev_ab_T1", ab(), 1);
        check("rev_pos_T1", pos_s(), -1);
        tick(1);
        check("rev_ab_T2", ab(), 3);
        check("rev_pos_T2", pos_s(), -2);
        check("rev_done_T2", int'(done), 1);

        // Zero-step command: done one cycle after edge T+1, no A/B change
        tick(1);
        send(0, 5);
        check("zero_ready_T", int'(cmd_ready), 1);
        check("zero_done_T", int'(done), 0);
        check("zero_busy_T", int'(busy), 0);
        tick(1);
        check("zero_done_T1", int'(done), 1);
        check("zero_ab_T1", ab(), 3);
        check("zero_pos_T1", pos_s(), -2);
        check("zero_ready_T1", int'(cmd_ready), 1);
        tick(1);
        check("zero_done_T2", int'(done), 0);

        // Abort mid-run from a fresh reset
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        send(10, 2);
        tick(4);
        check("abt_ab_T4", ab(), 3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abt_busy_T5", int'(busy), 0);
        check("abt_ready_T5", int'(cmd_ready), 1);
        check("abt_done_T5", int'(done), 0);
        tick(1);
        check("abt_ab_T6", ab(), 3);
        check("abt_pos_T6", pos_s(), 2);
        check("abt_done_T6", int'(done), 0);
        check("abt_ready_T6", int'(cmd_ready), 1);
        send(1, 1);
        tick(1);
        check("abt_next_ab", ab(), 1);
        check("abt_next_pos", pos_s(), 3);
        check("abt_next_done", int'(done), 1);

        // Wrap: preload max positive then one more step
        clear_pos();
        send(2047, 1);
        tick(2047);
        check("wrap_pre_pos", pos_s(), 2047);
        check("wrap_pre_ab", ab(), 3);
        check("wrap_pre_done", int'(done), 1);
        send(1, 1);
        tick(1);
        check("wrap_pos", pos_s(), -2048);
        check("wrap_ab", ab(), 1);

        // pos_clear coinciding with an edge: clear wins, edge still emitted
        send(1, 3);
        tick(2);
        pos_clear = 1'b1;
        tick(1);
        pos_clear = 1'b0;
        check("clr_edge_pos", pos_s(), 0);
        check("clr_edge_ab", ab(), 0);
        check("clr_edge_done", int'(done), 1);

        // Most negative command: 2048 edges with no magnitude overflow
        send(-2048, 1);
        tick(2047);
        check("neg_busy_pre", int'(busy), 1);
        check("neg_done_pre", int'(done), 0);
        tick(1);
        check("neg_done", int'(done), 1);
        check("neg_pos", pos_s(), -2048);
        check("neg_ab", ab(), 0);

        // Reset mid-run
        send(8, 2);
        tick(3);
        check("mrst_ab_pre", ab(), 2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("mrst_ab", ab(), 0);
        check("mrst_pos", pos_s(), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_ready", int'(cmd_ready), 1);

        // Loopback into a decoder: +1000 then -5 steps at P=8
        tick(1);
        dec_clr = 1'b0;
        send(1000, 8);
        tick(8000);
        tick(2);
        check("loop_dec_fwd", dec_cnt, 1000);
        check("loop_pos_fwd", pos_s(), 1000);
        send(-5, 8);
        tick(42);
        check("loop_dec_rev", dec_cnt, 995);
        check("loop_pos_rev", pos_s(), 995);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
